// File: rtl/vecgate_scoreboard.sv
// vecgate_scoreboard: checks the vector-gates block against a reference model.
// For each accepted sample it compares the bitwise-OR, logical-OR and NOT
// results. It keeps saturating per-field and total error counters and stamps
// the sample index of the first error per field. After N_SAMPLES accepted
// samples it stops and shows a pass/fail verdict.
//
// Handshake: a sample is consumed on a rising edge iff the block is in RUN
// and sample_valid is high. There is no backpressure; sample_valid outside
// RUN is ignored. start is honoured in IDLE or DONE only. A start in DONE
// that arrives with sample_valid opens a fresh run and drops that sample.
module vecgate_scoreboard #(
    parameter int CNT_W     = 16,
    parameter int ERR_W     = 16,
    parameter int N_SAMPLES = 430
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [2:0]       ref_or_bitwise,
    input  logic [2:0]       dut_or_bitwise,
    input  logic             ref_or_logical,
    input  logic             dut_or_logical,
    input  logic [5:0]       ref_not,
    input  logic [5:0]       dut_not,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [ERR_W-1:0] err_total,
    output logic [ERR_W-1:0] err_bitwise,
    output logic [ERR_W-1:0] err_logical,
    output logic [ERR_W-1:0] err_not,
    output logic [CNT_W-1:0] first_err_total,
    output logic [CNT_W-1:0] first_err_bitwise,
    output logic [CNT_W-1:0] first_err_logical,
    output logic [CNT_W-1:0] first_err_not
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // An all-ones stamp means no error has been seen for that field yet.
    localparam logic [CNT_W-1:0] STAMP_NONE = '1;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N_SAMPLES - 1);

    state_e           state_q, state_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [ERR_W-1:0] err_total_q, err_total_d;
    logic [ERR_W-1:0] err_bitwise_q, err_bitwise_d;
    logic [ERR_W-1:0] err_logical_q, err_logical_d;
    logic [ERR_W-1:0] err_not_q, err_not_d;
    logic [CNT_W-1:0] first_total_q, first_total_d;
    logic [CNT_W-1:0] first_bitwise_q, first_bitwise_d;
    logic [CNT_W-1:0] first_logical_q, first_logical_d;
    logic [CNT_W-1:0] first_not_q, first_not_d;

    logic accept;
    logic start_run;
    logic flag_b, flag_l, flag_n, flag_t;

    // Add one to a counter unless the flag is clear or the counter is saturated.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt,
                                                 input logic             flag);
        if (flag && (cnt != ERR_MAX)) begin
            return cnt + ERR_W'(1);
        end
        return cnt;
    endfunction

    // Stamp the current index only on the first error of the run.
    function automatic logic [CNT_W-1:0] stamp(input logic [CNT_W-1:0] cur,
                                               input logic             flag,
                                               input logic [CNT_W-1:0] idx);
        if (flag && (cur == STAMP_NONE)) begin
            return idx;
        end
        return cur;
    endfunction

    // Per-field compare flags, the accept qualifier and the start qualifier.
    always_comb begin
        flag_b    = (ref_or_bitwise != dut_or_bitwise);
        flag_l    = (ref_or_logical != dut_or_logical);
        flag_n    = (ref_not != dut_not);
        flag_t    = flag_b | flag_l | flag_n;
        accept    = (state_q == ST_RUN) && sample_valid;
        start_run = start && (state_q != ST_RUN);
    end

    // Next-state logic for the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept && (sample_cnt_q == LAST_IDX)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the counters, stamps and mismatch pulse.
    always_comb begin
        mismatch_d      = 1'b0;
        sample_cnt_d    = sample_cnt_q;
        err_total_d     = err_total_q;
        err_bitwise_d   = err_bitwise_q;
        err_logical_d   = err_logical_q;
        err_not_d       = err_not_q;
        first_total_d   = first_total_q;
        first_bitwise_d = first_bitwise_q;
        first_logical_d = first_logical_q;
        first_not_d     = first_not_q;
        if (start_run) begin
            sample_cnt_d    = '0;
            err_total_d     = '0;
            err_bitwise_d   = '0;
            err_logical_d   = '0;
            err_not_d       = '0;
            first_total_d   = STAMP_NONE;
            first_bitwise_d = STAMP_NONE;
            first_logical_d = STAMP_NONE;
            first_not_d     = STAMP_NONE;
        end else if (accept) begin
            mismatch_d      = flag_t;
            sample_cnt_d    = sample_cnt_q + CNT_W'(1);
            err_total_d     = sat_inc(err_total_q, flag_t);
            err_bitwise_d   = sat_inc(err_bitwise_q, flag_b);
            err_logical_d   = sat_inc(err_logical_q, flag_l);
            err_not_d       = sat_inc(err_not_q, flag_n);
            first_total_d   = stamp(first_total_q, flag_t, sample_cnt_q);
            first_bitwise_d = stamp(first_bitwise_q, flag_b, sample_cnt_q);
            first_logical_d = stamp(first_logical_q, flag_l, sample_cnt_q);
            first_not_d     = stamp(first_not_q, flag_n, sample_cnt_q);
        end
    end

    // State and datapath registers; reset returns everything to the idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            mismatch_q      <= 1'b0;
            sample_cnt_q    <= '0;
            err_total_q     <= '0;
            err_bitwise_q   <= '0;
            err_logical_q   <= '0;
            err_not_q       <= '0;
            first_total_q   <= STAMP_NONE;
            first_bitwise_q <= STAMP_NONE;
            first_logical_q <= STAMP_NONE;
            first_not_q     <= STAMP_NONE;
        end else begin
            state_q         <= state_d;
            mismatch_q      <= mismatch_d;
            sample_cnt_q    <= sample_cnt_d;
            err_total_q     <= err_total_d;
            err_bitwise_q   <= err_bitwise_d;
            err_logical_q   <= err_logical_d;
            err_not_q       <= err_not_d;
            first_total_q   <= first_total_d;
            first_bitwise_q <= first_bitwise_d;
            first_logical_q <= first_logical_d;
            first_not_q     <= first_not_d;
        end
    end

    // Outputs come straight from registers. The verdict is gated by DONE.
    always_comb begin
        busy              = (state_q == ST_RUN);
        done              = (state_q == ST_DONE);
        pass              = (state_q == ST_DONE) && (err_total_q == '0);
        mismatch          = mismatch_q;
        sample_cnt        = sample_cnt_q;
        err_total         = err_total_q;
        err_bitwise       = err_bitwise_q;
        err_logical       = err_logical_q;
        err_not           = err_not_q;
        first_err_total   = first_total_q;
        first_err_bitwise = first_bitwise_q;
        first_err_logical = first_logical_q;
        first_err_not     = first_not_q;
    end

endmodule
